fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Drives the fetch stage: owns the fetch PC and issues word requests to instruction memory over a
//  valid/ready request channel with an in-order response channel. Pairs each response with its PC and
//  buffers the result toward decode (valid/ready). Applies execute-stage redirects, discarding stale in-flight fetches.
//  Sits between the execute redirect inputs, the instruction memory and the decode stage.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset (word aligned)
//  DEPTH     2              max fetches in flight + buffered (credit limit); power of two, >=2
// PORTS
//  clk                in   1   clock; all state on rising edge
//  rst                in   1   reset, asynchronous, active-high
//  fetch_en           in   1   1 = issue fetches; 0 = halt issuing
//  pc_select_execute  in   1   redirect strobe from execute
//  pc_target_execute  in   32  redirect target; bits [1:0] ignored (forced 00)
//  imem_req_valid     out  1   request valid
//  imem_req_ready     in   1   memory accepts request
//  imem_req_addr      out  32  request byte address (word aligned)
//  imem_rsp_valid     in   1   response valid; in order, >=1 cycle after accept
//  imem_rsp_data      in   32  fetched instruction word
//  if_valid           out  1   instruction available to decode
//  if_ready           in   1   decode accepts
//  pc_fetch           out  32  PC of presented instruction
//  next_pc_fetch      out  32  pc_fetch + 4 (mod 2^32)
//  instruction_fetch  out  32  presented instruction
//  rsp_err            out  1   sticky: response arrived with nothing in flight
// BEHAVIOUR
//  - Reset (async assert, sync release): state BOOT, fetch PC = RESET_PC, counters 0, FIFOs empty,
//    imem_req_valid=0, if_valid=0, pc_fetch=0, next_pc_fetch=4, instruction_fetch=32'h0000_0013, rsp_err=0.
//  - FSM: BOOT -> RUN after 1 cycle (no request in BOOT). RUN -> HALT when fetch_en=0; HALT -> RUN when fetch_en=1.
//    Redirects are accepted in every state except BOOT, where they are ignored.
//  - Issue: imem_req_valid = (RUN) & (inflight + buffered < DEPTH). Driven from registered state only (no comb path
//    from pc_select_execute). On handshake: fetch PC += 4 (wraps FFFF_FFFC -> 0), PC pushed to pc FIFO, inflight++.
//  - Response: pops pc FIFO, inflight--. If drop_cnt>0: discard, drop_cnt--. Else push {pc,data} to output FIFO.
//    Output FIFO never overflows (credit rule). If imem_rsp_valid with inflight=0 -> ignore, set rsp_err.
//  - Output: if_valid = output FIFO not empty; pc_fetch/instruction_fetch = head; pop on if_valid & if_ready.
//    When empty, hold reset values for pc_fetch/instruction_fetch. Min latency req accept -> if_valid: rsp cycle + 1.
//  - Redirect (pc_select_execute=1 in cycle T): at T+1 fetch PC = {target[31:2],2'b00}; output FIFO flushed;
//    drop_cnt = inflight after T's updates (a request accepted in T counts; a response in T is discarded).
//    An if handshake in T completes (downstream squashes it). A second redirect while drop_cnt>0 adds the new in-flight count.
//  - HALT: no new requests; in-flight responses still delivered/dropped normally.
//  - Reset mid-operation: all state cleared immediately; responses after release with inflight=0 set rsp_err.
// STRUCTURE
//  - fetch_pkg: RESET_PC default, NOP = 32'h0000_0013, FSM encoding {BOOT,RUN,HALT}, counter width $clog2(DEPTH)+1.
//  - Sub-module fetch_fifo (param WIDTH, DEPTH; push/pop/flush/full/empty/head), instantiated twice:
//    pc FIFO (32b) and output FIFO (64b {pc,instr}).
// TESTING
//  1. Reset release, RESET_PC=0, ready=1, 1-cycle rsp DEADBEEF, BAADC0DE -> reqs 0x0, 0x4; if_valid pc 0/DEADBEEF, next_pc 4.
//  2. if_ready=0 -> exactly 2 reqs issued, imem_req_valid=0 after; one pop -> 1 new req at 0x8.
//  3. Two in flight (0x8, 0xC), redirect to 0x43 -> both rsps dropped; next req 0x40; first if_valid pc 0x40.
//  4. Redirect in same cycle as rsp and req accept -> that rsp and the accepted req both dropped; no stale pc output.
//  5. fetch_en=0 with 1 in flight -> no new reqs, pending instr delivered; fetch_en=1 -> resumes at next PC.
//  6. rst mid-run with 2 in flight -> outputs at reset values immediately; late rsp -> rsp_err=1, if_valid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: reset PC default, NOP word,
// FSM state encoding and the credit counter width helper.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP          = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // Counters must hold the value DEPTH itself, hence one extra bit.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for the in-flight PC queue and the decode
// output queue.
// Ports: clk, rst (async, active-high), push/pop/flush strobes, data in,
//        head (oldest entry), full, empty, count (occupancy).
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       data,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = mem[rd_ptr];

   // Storage needs no reset: entries are only visible once pushed.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch stage sequencer: owns the fetch PC, issues word requests to imem,
// pairs in-order responses with their PC and buffers them toward decode.
// Execute redirects reload the PC and squash every older in-flight fetch.
// Ports:
//   clk, rst                    clock, async active-high reset
//   fetch_en                    1 = issue fetches, 0 = halt issuing
//   pc_select_execute/target    redirect strobe and target (bits [1:0] ignored)
//   imem_req_valid/ready/addr   request channel
//   imem_rsp_valid/data         in-order response channel
//   if_valid/ready              decode handshake
//   pc_fetch, next_pc_fetch     PC of presented instruction and PC + 4
//   instruction_fetch           presented instruction
//   rsp_err                     sticky: response seen with nothing in flight
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_en,
   input  logic        pc_select_execute,
   input  logic [31:0] pc_target_execute,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] pc_fetch,
   output logic [31:0] next_pc_fetch,
   output logic [31:0] instruction_fetch,
   output logic        rsp_err
);

   localparam int CW = cnt_width(DEPTH);

   fetch_state_e state_q;
   fetch_state_e state_d;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] inflight_d;
   logic [CW-1:0] drop_cnt;

   logic          redirect;
   logic          credit;
   logic          req_fire;
   logic          rsp_ok;
   logic          drop_now;
   logic          outq_push;
   logic          if_pop;
   logic [31:0]   target;

   logic [31:0]   pcq_head;
   logic          pcq_full;
   logic          pcq_empty;
   logic [CW-1:0] pcq_count;
   logic [63:0]   outq_head;
   logic          outq_full;
   logic          outq_empty;
   logic [CW-1:0] outq_count;
   logic          unused_ok;

   assign unused_ok = ^{pcq_full, pcq_empty, pcq_count, outq_full};

   // Redirects are meaningless before the first fetch and are dropped in BOOT.
   assign redirect = pc_select_execute & (state_q != BOOT);
   assign target   = pc_target_execute & 32'hFFFF_FFFC;

   // A response with nothing outstanding is a protocol error, not data.
   assign rsp_ok   = imem_rsp_valid & (inflight != '0);
   assign drop_now = rsp_ok & (drop_cnt != '0);

   // A response in the redirect cycle is stale even when drop_cnt is zero.
   assign outq_push = rsp_ok & ~drop_now & ~redirect;

   // Credit covers both outstanding requests and buffered results, so the
   // output FIFO always has room for every response that comes back.
   assign credit = ({1'b0, inflight} + {1'b0, outq_count}) < (CW+1)'(DEPTH);

   assign req_fire   = imem_req_valid & imem_req_ready;
   assign inflight_d = inflight + CW'(req_fire) - CW'(rsp_ok);
   assign if_pop     = if_valid & if_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      imem_req_valid = 1'b0;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            imem_req_valid = credit;
            if (!fetch_en) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (fetch_en) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
         rsp_err  <= 1'b0;
      end else begin
         inflight <= inflight_d;
         if (redirect) begin
            fetch_pc <= target;
         end else if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         // Every fetch outstanding after a redirect is older than it.
         if (redirect) begin
            drop_cnt <= inflight_d;
         end else if (drop_now) begin
            drop_cnt <= drop_cnt - CW'(1);
         end
         if (imem_rsp_valid && inflight == '0) begin
            rsp_err <= 1'b1;
         end
      end
   end

   assign imem_req_addr = fetch_pc;

   fetch_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_pc_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_fire),
      .pop   (rsp_ok),
      .flush (1'b0),
      .data  (fetch_pc),
      .head  (pcq_head),
      .full  (pcq_full),
      .empty (pcq_empty),
      .count (pcq_count)
   );

   fetch_fifo #(
      .WIDTH (64),
      .DEPTH (DEPTH)
   ) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (outq_push),
      .pop   (if_pop),
      .flush (redirect),
      .data  ({pcq_head, imem_rsp_data}),
      .head  (outq_head),
      .full  (outq_full),
      .empty (outq_empty),
      .count (outq_count)
   );

   assign if_valid          = ~outq_empty;
   assign pc_fetch          = outq_empty ? 32'h0 : outq_head[63:32];
   assign instruction_fetch = outq_empty ? NOP : outq_head[31:0];
   assign next_pc_fetch     = pc_fetch + 32'd4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// phase, all checked against a queue-based model of fetch behaviour.
module tb_fetch_sequencer;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;
   localparam logic [31:0] NOPW  = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        fetch_en;
   logic        pc_select_execute;
   logic [31:0] pc_target_execute;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] pc_fetch;
   logic [31:0] next_pc_fetch;
   logic [31:0] instruction_fetch;
   logic        rsp_err;

   fetch_sequencer #(
      .RESET_PC (RPC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .fetch_en          (fetch_en),
      .pc_select_execute (pc_select_execute),
      .pc_target_execute (pc_target_execute),
      .imem_req_valid    (imem_req_valid),
      .imem_req_ready    (imem_req_ready),
      .imem_req_addr     (imem_req_addr),
      .imem_rsp_valid    (imem_rsp_valid),
      .imem_rsp_data     (imem_rsp_data),
      .if_valid          (if_valid),
      .if_ready          (if_ready),
      .pc_fetch          (pc_fetch),
      .next_pc_fetch     (next_pc_fetch),
      .instruction_fetch (instruction_fetch),
      .rsp_err           (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
      int          due;
      bit          stale;
   } fl_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } out_t;

   fl_t         infl_q[$];
   out_t        out_q[$];
   logic [31:0] fix_q[$];
   logic [31:0] m_pc;
   bit          m_boot;
   bit          m_run;
   bit          m_err;

   int total;
   int bad;
   int cyc;
   int dut_fires;
   int p_ready;
   int p_rsp;
   int p_dready;
   int lat_max;
   bit force_rsp;

   function automatic bit exp_rv();
      return m_run && ((infl_q.size() + out_q.size()) < DEPTH);
   endfunction

   task automatic model_reset();
      infl_q.delete();
      out_q.delete();
      m_pc   = RPC;
      m_boot = 1'b1;
      m_run  = 1'b0;
      m_err  = 1'b0;
   endtask

   task automatic quiet_inputs();
      imem_req_ready    = 1'b0;
      imem_rsp_valid    = 1'b0;
      imem_rsp_data     = 32'h0;
      if_ready          = 1'b0;
      pc_select_execute = 1'b0;
      pc_target_execute = 32'h0;
   endtask

   // One clock: drive inputs, compare outputs at negedge, advance the model.
   task automatic run_cycle(input bit redir, input logic [31:0] tgt);
      bit          rsp;
      bit          ev;
      bit          iv;
      bit          fire;
      bit          eff;
      logic [31:0] d;
      logic [31:0] epc;
      logic [31:0] eins;
      fl_t         f;
      imem_req_ready = ($urandom_range(99) < p_ready);
      rsp = force_rsp ||
            (infl_q.size() > 0 && infl_q[0].due <= cyc &&
             $urandom_range(99) < p_rsp);
      imem_rsp_valid    = rsp;
      imem_rsp_data     = (infl_q.size() > 0) ? infl_q[0].data : $urandom;
      if_ready          = ($urandom_range(99) < p_dready);
      pc_select_execute = redir;
      pc_target_execute = tgt;
      @(negedge clk);
      ev   = exp_rv();
      iv   = out_q.size() > 0;
      epc  = iv ? out_q[0].pc : 32'h0;
      eins = iv ? out_q[0].ins : NOPW;
      total++;
      if (imem_req_valid !== ev) begin
         bad++;
         $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, ev);
      end
      if (ev) begin
         total++;
         if (imem_req_addr !== m_pc) begin
            bad++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_pc);
         end
      end
      total++;
      if (if_valid !== iv) begin
         bad++;
         $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, if_valid, iv);
      end
      total++;
      if (pc_fetch !== epc || instruction_fetch !== eins ||
          next_pc_fetch !== epc + 32'd4) begin
         bad++;
         $display("FAIL if_data cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc,
                  pc_fetch, instruction_fetch, next_pc_fetch,
                  epc, eins, epc + 32'd4);
      end
      total++;
      if (rsp_err !== m_err) begin
         bad++;
         $display("FAIL rsp_err cyc=%0d got=%b exp=%b", cyc, rsp_err, m_err);
      end
      if (imem_req_valid && imem_req_ready) begin
         dut_fires++;
      end
      fire = ev && imem_req_ready;
      eff  = redir && !m_boot;
      if (iv && if_ready) begin
         void'(out_q.pop_front());
      end
      if (rsp) begin
         if (infl_q.size() == 0) begin
            m_err = 1'b1;
         end else begin
            f = infl_q.pop_front();
            if (!f.stale && !eff) begin
               out_q.push_back('{pc: f.pc, ins: f.data});
            end
         end
      end
      if (fire) begin
         d = (fix_q.size() > 0) ? fix_q.pop_front() : $urandom;
         infl_q.push_back('{pc: m_pc, data: d,
                            due: cyc + 1 + int'($urandom_range(lat_max)),
                            stale: 1'b0});
      end
      if (eff) begin
         foreach (infl_q[i]) infl_q[i].stale = 1'b1;
         out_q.delete();
         m_pc = tgt & 32'hFFFF_FFFC;
      end else if (fire) begin
         m_pc = m_pc + 32'd4;
      end
      if (m_boot) begin
         m_boot = 1'b0;
         m_run  = 1'b1;
      end else begin
         m_run = fetch_en;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      int n;
      p_ready  = 0;
      p_rsp    = 100;
      p_dready = 100;
      n = 0;
      while ((infl_q.size() > 0 || out_q.size() > 0) && n < 30) begin
         run_cycle(1'b0, 32'h0);
         n++;
      end
      total++;
      if (infl_q.size() > 0 || out_q.size() > 0) begin
         bad++;
         $display("FAIL drain_timeout got=%0d/%0d exp=0/0", infl_q.size(), out_q.size());
      end
   endtask

   task automatic test_reset();
      quiet_inputs();
      fetch_en = 1'b1;
      rst      = 1'b1;
      #3;
      total++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_fetch !== 32'h0 ||
          next_pc_fetch !== 32'h4 || instruction_fetch !== NOPW || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got=%b%b %h %h %h %b exp=00 0 4 13 0",
                  if_valid, imem_req_valid, pc_fetch, next_pc_fetch,
                  instruction_fetch, rsp_err);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int f0;
      fix_q.push_back(32'hDEAD_BEEF);
      fix_q.push_back(32'hBAAD_C0DE);
      lat_max  = 0;
      p_ready  = 100;
      p_rsp    = 100;
      p_dready = 0;
      f0 = dut_fires;
      repeat (5) run_cycle(1'b0, 32'h0);
      total++;
      if (if_valid !== 1'b1 || pc_fetch !== 32'h0 ||
          instruction_fetch !== 32'hDEAD_BEEF || next_pc_fetch !== 32'h4) begin
         bad++;
         $display("FAIL basic_first got=%b %h %h %h exp=1 0 deadbeef 4",
                  if_valid, pc_fetch, instruction_fetch, next_pc_fetch);
      end
      total++;
      if (dut_fires - f0 != 2) begin
         bad++;
         $display("FAIL basic_reqs got=%0d exp=2", dut_fires - f0);
      end
   endtask

   task automatic test_backpressure();
      int f0;
      f0 = dut_fires;
      repeat (4) run_cycle(1'b0, 32'h0);
      total++;
      if (imem_req_valid !== 1'b0 || dut_fires != f0) begin
         bad++;
         $display("FAIL bp_stall got=%b/%0d exp=0/0", imem_req_valid, dut_fires - f0);
      end
      p_dready = 100;
      p_rsp    = 0;
      run_cycle(1'b0, 32'h0);
      p_dready = 0;
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
         bad++;
         $display("FAIL bp_resume got=%b/%h exp=1/00000008", imem_req_valid, imem_req_addr);
      end
      run_cycle(1'b0, 32'h0);
      total++;
      if (imem_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL bp_one got=%b exp=0", imem_req_valid);
      end
   endtask

   task automatic test_redirect();
      int n;
      p_dready = 100;
      run_cycle(1'b0, 32'h0);
      p_dready = 0;
      run_cycle(1'b0, 32'h0);
      total++;
      if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
         bad++;
         $display("FAIL redir_setup got=%b/%b exp=0/0", imem_req_valid, if_valid);
      end
      run_cycle(1'b1, 32'h0000_0043);
      p_rsp = 100;
      n = 0;
      while (!imem_req_valid && n < 10) begin
         run_cycle(1'b0, 32'h0);
         n++;
      end
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40) begin
         bad++;
         $display("FAIL redir_addr got=%b/%h exp=1/00000040", imem_req_valid, imem_req_addr);
      end
      n = 0;
      while (!if_valid && n < 10) begin
         run_cycle(1'b0, 32'h0);
         n++;
      end
      total++;
      if (if_valid !== 1'b1 || pc_fetch !== 32'h40) begin
         bad++;
         $display("FAIL redir_first got=%b/%h exp=1/00000040", if_valid, pc_fetch);
      end
   endtask

   task automatic test_collide();
      int n;
      lat_max = 0;
      drain();
      p_ready = 100;
      p_rsp   = 0;
      run_cycle(1'b0, 32'h0);
      p_rsp = 100;
      run_cycle(1'b1, 32'h0000_0200);
      total++;
      if (if_valid !== 1'b0 || imem_req_addr !== 32'h200) begin
         bad++;
         $display("FAIL collide_flush got=%b/%h exp=0/00000200", if_valid, imem_req_addr);
      end
      p_ready = 0;
      run_cycle(1'b0, 32'h0);
      total++;
      if (if_valid !== 1'b0) begin
         bad++;
         $display("FAIL collide_stale got=%b/%h exp=0", if_valid, pc_fetch);
      end
      p_ready = 100;
      n = 0;
      while (!if_valid && n < 10) begin
         run_cycle(1'b0, 32'h0);
         n++;
      end
      total++;
      if (if_valid !== 1'b1 || pc_fetch !== 32'h200) begin
         bad++;
         $display("FAIL collide_first got=%b/%h exp=1/00000200", if_valid, pc_fetch);
      end
   endtask

   task automatic test_halt();
      logic [31:0] p;
      int          f0;
      int          n;
      drain();
      p   = m_pc;
      p_ready  = 100;
      p_rsp    = 0;
      p_dready = 0;
      run_cycle(1'b0, 32'h0);
      fetch_en = 1'b0;
      p_ready  = 0;
      run_cycle(1'b0, 32'h0);
      p_ready = 100;
      p_rsp   = 100;
      f0 = dut_fires;
      repeat (4) run_cycle(1'b0, 32'h0);
      total++;
      if (dut_fires != f0 || if_valid !== 1'b1 || pc_fetch !== p) begin
         bad++;
         $display("FAIL halt_hold got=%0d/%b/%h exp=0/1/%h", dut_fires - f0, if_valid, pc_fetch, p);
      end
      fetch_en = 1'b1;
      p_dready = 100;
      n = 0;
      while (!imem_req_valid && n < 10) begin
         run_cycle(1'b0, 32'h0);
         n++;
      end
      total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== p + 32'd4) begin
         bad++;
         $display("FAIL halt_resume got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, p + 32'd4);
      end
   endtask

   task automatic test_random();
      bit          rd;
      logic [31:0] tg;
      lat_max = 3;
      for (int i = 0; i < 500; i++) begin
         if (i % 50 == 0) begin
            p_ready  = 20 + int'($urandom_range(80));
            p_rsp    = 20 + int'($urandom_range(80));
            p_dready = int'($urandom_range(100));
         end
         if ($urandom_range(99) < 8) begin
            fetch_en = ~fetch_en;
         end
         rd = ($urandom_range(99) < 6);
         tg = $urandom;
         if ($urandom_range(3) == 0) begin
            tg = 32'hFFFF_FFF0 | {28'h0, tg[3:0]};
         end
         run_cycle(rd, tg);
      end
      fetch_en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int n;
      lat_max = 0;
      drain();
      p_ready  = 100;
      p_rsp    = 0;
      p_dready = 0;
      n = 0;
      while (infl_q.size() < 2 && n < 10) begin
         run_cycle(1'b0, 32'h0);
         n++;
      end
      #2;
      rst = 1'b1;
      quiet_inputs();
      #1;
      total++;
      if (if_valid !== 1'b0 || imem_req_valid !== 1'b0 || pc_fetch !== 32'h0 ||
          next_pc_fetch !== 32'h4 || instruction_fetch !== NOPW || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL midreset_state got=%b%b %h %h %h %b exp=00 0 4 13 0",
                  if_valid, imem_req_valid, pc_fetch, next_pc_fetch,
                  instruction_fetch, rsp_err);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      p_ready   = 0;
      force_rsp = 1'b1;
      run_cycle(1'b1, 32'h0000_0100);
      force_rsp = 1'b0;
      total++;
      if (rsp_err !== 1'b1 || if_valid !== 1'b0) begin
         bad++;
         $display("FAIL late_rsp got=%b/%b exp=1/0", rsp_err, if_valid);
      end
      p_ready = 100;
      p_rsp   = 100;
      repeat (4) run_cycle(1'b0, 32'h0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      cyc       = 0;
      dut_fires = 0;
      force_rsp = 1'b0;
      lat_max   = 0;
      p_ready   = 0;
      p_rsp     = 0;
      p_dready  = 0;
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect();
      test_collide();
      test_halt();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
